// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage MIPS core.
// Produces the IF/ID hold/flush, the PC write enable, the ID/EX bubble select
// and the pipeline freeze, from load-use hazards, taken branches/jumps and
// data-memory wait states.
//
// Optional build macro: HAZARD_STATS_EN. It enables saturating statistics
// counters. Without it the counter ports read 0 and no counter flops exist.
//
// state       | meaning
// ------------+--------------------------------------------------------------
// ST_RUN      | normal flow; mem stall > load-use > branch > advance
// ST_MEM_WAIT | data memory access outstanding; pipeline frozen, wait timed
// ST_ERROR    | memory access exceeded MEM_TIMEOUT; frozen until reset
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [31:0]      ifid_inst_i,
  input  logic             idex_memread_i,
  input  logic [4:0]       idex_rt_i,
  input  logic             branch_taken_i,
  input  logic             mem_req_i,
  input  logic             mem_ready_i,
  output logic             pc_write_o,
  output logic             hazard_o,
  output logic             flush_o,
  output logic             idex_bubble_o,
  output logic             freeze_o,
  output logic             err_o,
  output logic [CNT_W-1:0] lu_cnt_o,
  output logic [CNT_W-1:0] br_cnt_o,
  output logic [CNT_W-1:0] mem_cnt_o
);

  localparam int TO_W   = $clog2(MEM_TIMEOUT + 1);
  localparam int WAIT_W = (TO_W > 8) ? TO_W : 8;
  localparam logic [WAIT_W-1:0] TIMEOUT_VAL = WAIT_W'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic [4:0] rs, rt;
  logic       mem_stall, load_use;
  logic       pc_write, hazard, flush, idex_bubble, freeze;

  // Opcode/immediate bits of the instruction are not needed here.
  logic unused_inst_bits;
  assign unused_inst_bits = ^{ifid_inst_i[31:26], ifid_inst_i[15:0]};

  assign rs        = ifid_inst_i[25:21];
  assign rt        = ifid_inst_i[20:16];
  assign mem_stall = mem_req_i & ~mem_ready_i;
  assign load_use  = idex_memread_i & (idex_rt_i != 5'd0) &
                     ((idex_rt_i == rs) | (idex_rt_i == rt));

  // State and wait-timer register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next state, wait timer and pipeline control. A completed (or abandoned)
  // memory access leaves MEM_WAIT and applies the RUN rules in the same cycle.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    pc_write    = 1'b0;
    hazard      = 1'b0;
    flush       = 1'b0;
    idex_bubble = 1'b0;
    freeze      = 1'b0;
    case (state_q)
      ST_RUN, ST_MEM_WAIT: begin
        if (mem_stall) begin
          freeze = 1'b1;
          hazard = 1'b1;
          if (state_q == ST_RUN) begin
            state_d    = ST_MEM_WAIT;
            wait_cnt_d = WAIT_W'(1);
          end else if (wait_cnt_q == TIMEOUT_VAL) begin
            state_d = ST_ERROR;
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end
        end else begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
          // A branch alongside a load-use is dropped; it re-resolves next
          // cycle once the load data can be forwarded.
          if (load_use) begin
            hazard      = 1'b1;
            idex_bubble = 1'b1;
          end else if (branch_taken_i) begin
            flush    = 1'b1;
            pc_write = 1'b1;
          end else begin
            pc_write = 1'b1;
          end
        end
      end
      ST_ERROR: begin
        freeze = 1'b1;
        hazard = 1'b1;
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Outputs are forced low while reset is held, since the RUN state alone
  // would otherwise enable the PC.
  assign pc_write_o    = rst_i & pc_write;
  assign hazard_o      = rst_i & hazard;
  assign flush_o       = rst_i & flush;
  assign idex_bubble_o = rst_i & idex_bubble;
  assign freeze_o      = rst_i & freeze;
  assign err_o         = rst_i & (state_q == ST_ERROR);

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] mem_cnt_q, mem_cnt_d;

  // Saturating event counters. Memory wait cycles are the frozen cycles
  // caused by an outstanding access, so ERROR cycles are not counted.
  always_comb begin
    lu_cnt_d  = lu_cnt_q;
    br_cnt_d  = br_cnt_q;
    mem_cnt_d = mem_cnt_q;
    if (idex_bubble && (lu_cnt_q != '1))
      lu_cnt_d = lu_cnt_q + CNT_W'(1);
    if (flush && (br_cnt_q != '1))
      br_cnt_d = br_cnt_q + CNT_W'(1);
    if (freeze && (state_q != ST_ERROR) && (mem_cnt_q != '1))
      mem_cnt_d = mem_cnt_q + CNT_W'(1);
  end

  // Statistics register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      lu_cnt_q  <= '0;
      br_cnt_q  <= '0;
      mem_cnt_q <= '0;
    end else begin
      lu_cnt_q  <= lu_cnt_d;
      br_cnt_q  <= br_cnt_d;
      mem_cnt_q <= mem_cnt_d;
    end
  end

  assign lu_cnt_o  = lu_cnt_q;
  assign br_cnt_o  = br_cnt_q;
  assign mem_cnt_o = mem_cnt_q;
`else
  assign lu_cnt_o  = '0;
  assign br_cnt_o  = '0;
  assign mem_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: table of single-cycle RUN vectors plus hand-written
// multi-cycle sequences for memory wait, timeout and reset.
module tb_hazard_ctrl;

  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 2;
`ifdef HAZARD_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [31:0]      ifid_inst_i;
  logic             idex_memread_i;
  logic [4:0]       idex_rt_i;
  logic             branch_taken_i;
  logic             mem_req_i;
  logic             mem_ready_i;
  logic             pc_write_o, hazard_o, flush_o, idex_bubble_o, freeze_o, err_o;
  logic [CNT_W-1:0] lu_cnt_o, br_cnt_o, mem_cnt_o;

  hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .ifid_inst_i    (ifid_inst_i),
    .idex_memread_i (idex_memread_i),
    .idex_rt_i      (idex_rt_i),
    .branch_taken_i (branch_taken_i),
    .mem_req_i      (mem_req_i),
    .mem_ready_i    (mem_ready_i),
    .pc_write_o     (pc_write_o),
    .hazard_o       (hazard_o),
    .flush_o        (flush_o),
    .idex_bubble_o  (idex_bubble_o),
    .freeze_o       (freeze_o),
    .err_o          (err_o),
    .lu_cnt_o       (lu_cnt_o),
    .br_cnt_o       (br_cnt_o),
    .mem_cnt_o      (mem_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // expected output packing: {pc_write, hazard, flush, bubble, freeze, err}
  localparam logic [5:0] O_IDLE  = 6'b100000;
  localparam logic [5:0] O_LU    = 6'b010100;
  localparam logic [5:0] O_BR    = 6'b101000;
  localparam logic [5:0] O_STALL = 6'b010010;
  localparam logic [5:0] O_ERR   = 6'b010011;
  localparam logic [5:0] O_ZERO  = 6'b000000;

  typedef struct {
    string       name;
    logic [31:0] inst;
    logic        memread;
    logic [4:0]  rt;
    logic        br;
    logic        req;
    logic        rdy;
    logic [5:0]  exp;
  } vec_t;

  typedef struct {
    string      name;
    logic [5:0] exp;
  } sb_t;

  sb_t        sb_q[$];
  vec_t       vecs[10];
  int         checks = 0;
  int         errors = 0;
  logic [1:0] lu_m, br_m, mem_m;

  function automatic logic [31:0] mk_inst(input logic [4:0] rs, input logic [4:0] rt);
    return {6'b100011, rs, rt, 16'h1234};
  endfunction

  function automatic logic [1:0] sat_inc(input logic [1:0] v);
    return (v == 2'b11) ? v : v + 2'd1;
  endfunction

  task automatic check(input string name, input logic [5:0] got, input logic [5:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b", name, got, exp);
    end
  endtask

  task automatic check_cnt(input string name);
    logic [5:0] exp;
    exp = STATS_ON ? {lu_m, br_m, mem_m} : 6'b0;
    check(name, {lu_cnt_o, br_cnt_o, mem_cnt_o}, exp);
  endtask

  // Called just after a posedge: drive, push expectation, compare at negedge.
  task automatic step(input string name, input logic [31:0] inst, input logic memread,
                      input logic [4:0] rt, input logic br, input logic req,
                      input logic rdy, input logic [5:0] exp);
    sb_t s;
    ifid_inst_i    = inst;
    idex_memread_i = memread;
    idex_rt_i      = rt;
    branch_taken_i = br;
    mem_req_i      = req;
    mem_ready_i    = rdy;
    sb_q.push_back('{name, exp});
    if (exp[2]) lu_m = sat_inc(lu_m);
    if (exp[3]) br_m = sat_inc(br_m);
    if (exp[1] && !exp[0]) mem_m = sat_inc(mem_m);
    @(negedge clk_i);
    s = sb_q.pop_front();
    check(s.name, {pc_write_o, hazard_o, flush_o, idex_bubble_o, freeze_o, err_o}, s.exp);
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input string name, input logic [5:0] exp);
    step(name, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, exp);
  endtask

  task automatic stall(input string name, input logic [5:0] exp);
    step(name, mk_inst(5'd5, 5'd6), 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, exp);
  endtask

  // Mid-cycle reset pulse; outputs and counters must clear at once.
  task automatic reset_pulse(input string name);
    rst_i = 1'b0;
    #1;
    lu_m = '0; br_m = '0; mem_m = '0;
    check({name, "_out"}, {pc_write_o, hazard_o, flush_o, idex_bubble_o, freeze_o, err_o}, O_ZERO);
    check_cnt({name, "_cnt"});
    #1;
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    vecs[0] = '{"idle",        32'h0,             1'b0, 5'd0, 1'b0, 1'b0, 1'b0, O_IDLE};
    vecs[1] = '{"lu_rs",       mk_inst(5'd5, 5'd3), 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, O_LU};
    vecs[2] = '{"lu_rt",       mk_inst(5'd1, 5'd7), 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, O_LU};
    vecs[3] = '{"lu_r0",       mk_inst(5'd0, 5'd0), 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, O_IDLE};
    vecs[4] = '{"no_load",     mk_inst(5'd5, 5'd3), 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, O_IDLE};
    vecs[5] = '{"lu_nomatch",  mk_inst(5'd2, 5'd3), 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, O_IDLE};
    vecs[6] = '{"branch",      mk_inst(5'd2, 5'd3), 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, O_BR};
    vecs[7] = '{"branch_lu",   mk_inst(5'd4, 5'd8), 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, O_LU};
    vecs[8] = '{"mem_ready",   32'h0,             1'b0, 5'd0, 1'b0, 1'b1, 1'b1, O_IDLE};
    vecs[9] = '{"rdy_branch",  32'h0,             1'b0, 5'd0, 1'b1, 1'b0, 1'b1, O_BR};

    lu_m = '0; br_m = '0; mem_m = '0;
    rst_i = 1'b0;
    ifid_inst_i = '0; idex_memread_i = 1'b0; idex_rt_i = '0;
    branch_taken_i = 1'b0; mem_req_i = 1'b0; mem_ready_i = 1'b0;
    @(posedge clk_i);
    #1;
    check("reset_out", {pc_write_o, hazard_o, flush_o, idex_bubble_o, freeze_o, err_o}, O_ZERO);
    check_cnt("reset_cnt");
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;

    foreach (vecs[i])
      step(vecs[i].name, vecs[i].inst, vecs[i].memread, vecs[i].rt,
           vecs[i].br, vecs[i].req, vecs[i].rdy, vecs[i].exp);
    check_cnt("table_cnt");

    // three wait cycles then ready; pipeline advances on the ready cycle
    reset_pulse("rst_a");
    for (int i = 0; i < 3; i++) stall("wait3", O_STALL);
    step("wait3_ready", 32'h0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, O_IDLE);
    idle("wait3_after", O_IDLE);
    check_cnt("wait3_cnt");

    // hazards ignored while waiting; dropped request releases with RUN rules
    stall("wait_b0", O_STALL);
    step("wait_b_lu_br", mk_inst(5'd5, 5'd6), 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, O_STALL);
    step("wait_b_drop", 32'h0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, O_BR);
    stall("wait_c0", O_STALL);
    step("wait_c_rdy_lu", mk_inst(5'd5, 5'd6), 1'b1, 5'd6, 1'b0, 1'b1, 1'b1, O_LU);

    // ready on the last permitted wait cycle still completes normally
    for (int i = 0; i < MEM_TIMEOUT; i++) stall("edge_wait", O_STALL);
    step("edge_ready", 32'h0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, O_IDLE);
    idle("edge_after", O_IDLE);

    // timeout: MEM_TIMEOUT+1 frozen cycles, then sticky error
    for (int i = 0; i <= MEM_TIMEOUT; i++) stall("to_wait", O_STALL);
    step("err_hold_rdy", 32'h0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, O_ERR);
    step("err_hold_br", mk_inst(5'd5, 5'd6), 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, O_ERR);
    idle("err_hold_idle", O_ERR);
    check_cnt("err_cnt");
    reset_pulse("rst_err");
    idle("after_err", O_IDLE);

    // asynchronous reset in the middle of a wait
    stall("mid_wait0", O_STALL);
    stall("mid_wait1", O_STALL);
    reset_pulse("rst_mid");
    idle("after_mid", O_IDLE);

    // branch counter saturation
    for (int i = 0; i < 5; i++)
      step("br_sat", 32'h0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, O_BR);
    check_cnt("br_sat_cnt");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "bench time limit");
  end

endmodule
